// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame width and
// the baud-rate divisor helper used by both directions.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

   localparam int DATA_BITS = 8;

   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return (clk_freq + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period down-counter. Holding start high runs it, and bit_done pulses on
// the last cycle of each bit. Dropping start parks the counter at zero.
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 872
) (
   input  logic uart_clk,
   input  logic reset,
   input  logic start,
   output logic bit_done
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;
   logic             run;

   generate
      if (CLKS_PER_BIT < 2) begin : g_cpb_check
         $error("uart_baud_gen: CLKS_PER_BIT must be at least 2");
      end
   endgenerate

   // The counter sits at zero while idle, so the first running cycle reloads.
   always_ff @(posedge uart_clk) begin
      if (reset || !start) begin
         cnt <= '0;
         run <= 1'b0;
      end else begin
         run <= 1'b1;
         cnt <= (cnt == '0) ? RELOAD : cnt - CNT_W'(1);
      end
   end

   assign bit_done = run && (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter with a valid/ready byte input and a registered TX pin.
//   state | meaning
//   IDLE  | line high, ready for a byte
//   START | start bit (low)
//   DATA  | data bits, LSB first
//   STOP  | stop bit(s), high
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 100_500_000,
   parameter int BAUD      = 115200,
   parameter int STOP_BITS = 1
) (
   input  logic       uart_clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       busy
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
   localparam logic LAST_STOP = (STOP_BITS == 2);

   generate
      if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_check
         $error("uart_tx: STOP_BITS must be 1 or 2");
      end
   endgenerate

   uart_tx_state_t state, state_n;
   logic [7:0] shift_reg, shift_n;
   logic [2:0] bit_idx, bit_idx_n;
   logic       stop_idx, stop_idx_n;
   logic       tx_n, ready_n, busy_n;
   logic       bit_done;

   uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .uart_clk (uart_clk),
      .reset    (reset),
      .start    (state_n != IDLE),
      .bit_done (bit_done)
   );

   always_ff @(posedge uart_clk) begin
      if (reset) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         tx        <= 1'b1;
         tx_ready  <= 1'b1;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         shift_reg <= shift_n;
         bit_idx   <= bit_idx_n;
         stop_idx  <= stop_idx_n;
         tx        <= tx_n;
         tx_ready  <= ready_n;
         busy      <= busy_n;
      end
   end

   always_comb begin
      state_n    = state;
      shift_n    = shift_reg;
      bit_idx_n  = bit_idx;
      stop_idx_n = stop_idx;
      unique case (state)
         IDLE: begin
            if (tx_valid) begin
               shift_n = tx_data;
               state_n = START;
            end
         end
         START: begin
            if (bit_done) begin
               bit_idx_n = '0;
               state_n   = DATA;
            end
         end
         DATA: begin
            if (bit_done) begin
               shift_n = shift_reg >> 1;
               if (bit_idx == LAST_BIT) begin
                  stop_idx_n = 1'b0;
                  state_n    = STOP;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end
         end
         STOP: begin
            if (bit_done) begin
               if (stop_idx == LAST_STOP) state_n = IDLE;
               else stop_idx_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      // Outputs are decoded from the next state so they register alongside it.
      tx_n    = (state_n == START) ? 1'b0 :
                (state_n == DATA)  ? shift_n[0] : 1'b1;
      ready_n = (state_n == IDLE);
      busy_n  = (state_n != IDLE);
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a fast 4-clock-per-bit instance, a two-stop-bit
// instance and a default-rate instance for the 872-cycle bit period.
module tb_uart_tx;

   logic       uart_clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] data_a, data_b, data_c;
   logic       valid_a, valid_b, valid_c;
   logic       rdy_a, rdy_b, rdy_c;
   logic       tx_a, tx_b, tx_c;
   logic       busy_a, busy_b, busy_c;

   int errors = 0;
   int checks = 0;
   int n;

   always #5 uart_clk = ~uart_clk;

   uart_tx #(.CLK_FREQ(8), .BAUD(2), .STOP_BITS(1)) dut_a (
      .uart_clk(uart_clk), .reset(reset), .tx_data(data_a), .tx_valid(valid_a),
      .tx_ready(rdy_a), .tx(tx_a), .busy(busy_a)
   );

   uart_tx #(.CLK_FREQ(8), .BAUD(2), .STOP_BITS(2)) dut_b (
      .uart_clk(uart_clk), .reset(reset), .tx_data(data_b), .tx_valid(valid_b),
      .tx_ready(rdy_b), .tx(tx_b), .busy(busy_b)
   );

   uart_tx dut_c (
      .uart_clk(uart_clk), .reset(reset), .tx_data(data_c), .tx_valid(valid_c),
      .tx_ready(rdy_c), .tx(tx_c), .busy(busy_c)
   );

   task automatic tick();
      @(posedge uart_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic [7:0] d, input logic v);
      if (sel) begin
         data_b  = d;
         valid_b = v;
      end else begin
         data_a  = d;
         valid_a = v;
      end
   endtask

   task automatic sample(input bit sel, output logic o_tx, output logic o_rdy, output logic o_busy);
      o_tx   = sel ? tx_b   : tx_a;
      o_rdy  = sel ? rdy_b  : rdy_a;
      o_busy = sel ? busy_b : busy_a;
   endtask

   // Called in IDLE; hands over d, then checks every cycle of the frame.
   task automatic run_frame(input bit sel, input logic [7:0] d, input logic [7:0] mid,
                            input int stops, input logic keep_valid,
                            input logic [7:0] end_d, input string tag);
      int   len;
      int   k;
      logic exp_tx, o_tx, o_rdy, o_busy;
      len = (9 + stops) * 4;
      drive(sel, d, 1'b1);
      tick();
      drive(sel, mid, keep_valid);
      for (int i = 0; i < len; i++) begin
         k = i / 4;
         exp_tx = (k == 0) ? 1'b0 : (k <= 8) ? d[k-1] : 1'b1;
         sample(sel, o_tx, o_rdy, o_busy);
         check({tag, " tx"}, o_tx, exp_tx);
         check({tag, " ready/busy"}, {o_rdy, o_busy}, 2'b01);
         if (i == len - 1) drive(sel, end_d, keep_valid);
         tick();
      end
      sample(sel, o_tx, o_rdy, o_busy);
      check({tag, " end idle"}, {o_tx, o_rdy, o_busy}, 3'b110);
   endtask

   initial begin
      data_a = '0; data_b = '0; data_c = '0;
      valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;

      for (int i = 0; i < 100; i++) begin
         check("reset idle a", {tx_a, rdy_a, busy_a}, 3'b110);
         tick();
      end
      check("reset idle b", {tx_b, rdy_b, busy_b}, 3'b110);
      check("reset idle c", {tx_c, rdy_c, busy_c}, 3'b110);

      // 0xA5: line shows 0,1,0,1,0,0,1,0,1,1
      run_frame(1'b0, 8'hA5, 8'hA5, 1, 1'b0, 8'h00, "a5");
      tick();

      // valid held high: second start bit 41 cycles after the first
      run_frame(1'b0, 8'h00, 8'h5A, 1, 1'b1, 8'hFF, "b2b first");
      run_frame(1'b0, 8'hFF, 8'h5A, 1, 1'b0, 8'h00, "b2b second");
      tick();

      // data changing mid-frame must not reach the line
      run_frame(1'b0, 8'h3C, 8'hC3, 1, 1'b0, 8'h00, "mid change");
      tick();

      // abort a frame with reset
      data_a = 8'h99; valid_a = 1'b1;
      tick();
      valid_a = 1'b0;
      repeat (12) tick();
      check("abort pre tx", tx_a, 1'b0);
      check("abort pre busy", busy_a, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort idle", {tx_a, rdy_a, busy_a}, 3'b110);
      tick();
      check("abort no stop", {tx_a, rdy_a, busy_a}, 3'b110);
      run_frame(1'b0, 8'h55, 8'h55, 1, 1'b0, 8'h00, "after abort");
      tick();

      // reset and valid together: nothing accepted
      data_a = 8'hF0; valid_a = 1'b1; reset = 1'b1;
      tick();
      reset = 1'b0; valid_a = 1'b0;
      check("rst+valid idle", {tx_a, rdy_a, busy_a}, 3'b110);
      tick();
      check("rst+valid no frame", {tx_a, rdy_a, busy_a}, 3'b110);

      // two stop bits: 44-cycle frame
      run_frame(1'b1, 8'h80, 8'h80, 2, 1'b0, 8'h00, "stop2");

      // default rate: start bit lasts 872 cycles
      data_c = 8'h01; valid_c = 1'b1;
      tick();
      valid_c = 1'b0;
      check("c start low", tx_c, 1'b0);
      n = 0;
      while (tx_c === 1'b0 && n < 2000) begin
         tick();
         n++;
      end
      check("c bit period", n, 872);
      check("c bit0 high", tx_c, 1'b1);
      check("c busy", busy_c, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
